ham_enc: RTL and testbench

Streaming extended-Hamming (SECDED) encoder for the three link modes: (8,4), (16,11) and (32,26). It accepts info words on a valid/ready input channel and emits systematic codewords on a valid/ready output channel through a two-stage pipeline. The codeword bit layout is exactly the one the decoder strips, with info in the upper bits and parity in the low bits. It sits on the transmit side of the link, feeding the channel that the decoder consumes.

---
 rtl/ham_pkg.sv | 91 +++++++++
 rtl/ham_enc_if.sv | 38 +++
 rtl/ham_par_gen.sv | 32 +++
 rtl/ham_enc.sv | 96 +++++++++
 tb/tb_ham_enc.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ham_pkg.sv
// Shared SECDED definitions for the link encoder/decoder: modes, widths, column map.
// Optional error-injection fields are present when ENC_ERR_INJECT_EN is defined.
package ham_pkg;

  localparam int unsigned MAX_CODEWORD_WIDTH = 32;
  localparam int unsigned MAX_INFO_WIDTH     = 26;
  localparam int unsigned PAR_W              = 6;
  localparam int unsigned HAM_W              = PAR_W - 1;
  localparam int unsigned POS_W              = 5;

  localparam int unsigned K_8_4   = 4;
  localparam int unsigned R_8_4   = 4;
  localparam int unsigned N_8_4   = 8;
  localparam int unsigned K_16_11 = 11;
  localparam int unsigned R_16_11 = 5;
  localparam int unsigned N_16_11 = 16;
  localparam int unsigned K_32_26 = 26;
  localparam int unsigned R_32_26 = 6;
  localparam int unsigned N_32_26 = 32;

  typedef enum logic [1:0] {
    MODE_8_4   = 2'b00,
    MODE_16_11 = 2'b01,
    MODE_32_26 = 2'b10,
    MODE_ILL   = 2'b11
  } ham_mode_e;

  typedef struct packed {
`ifdef ENC_ERR_INJECT_EN
    logic             inj_en;
    logic             inj_two;
    logic [POS_W-1:0] inj_pos0;
    logic [POS_W-1:0] inj_pos1;
`endif
    ham_mode_e                 mode;
    logic [MAX_INFO_WIDTH-1:0] info;
  } ham_beat_t;

  // Column of info bit idx: the idx-th integer >= 3 that is not a power of two.
  function automatic logic [HAM_W-1:0] ham_col(input int unsigned idx);
    logic [HAM_W-1:0] col;
    int unsigned      cnt;
    col = '0;
    cnt = 0;
    for (int unsigned v = 3; v < 32; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (cnt == idx) col = HAM_W'(v);
        cnt++;
      end
    end
    return col;
  endfunction

  // Info bits that feed Hamming parity bit j.
  function automatic logic [MAX_INFO_WIDTH-1:0] ham_row_mask(input int unsigned j);
    logic [MAX_INFO_WIDTH-1:0] m;
    logic [HAM_W-1:0]          c;
    m = '0;
    for (int unsigned i = 0; i < MAX_INFO_WIDTH; i++) begin
      c = ham_col(i);
      m[i[4:0]] = c[j[2:0]];
    end
    return m;
  endfunction

  function automatic logic [MAX_INFO_WIDTH-1:0] ham_info_mask(input ham_mode_e m);
    case (m)
      MODE_8_4:   return 26'h000_000F;
      MODE_16_11: return 26'h000_07FF;
      MODE_32_26: return 26'h3FF_FFFF;
      default:    return '0;
    endcase
  endfunction

  function automatic logic [2:0] ham_r(input ham_mode_e m);
    case (m)
      MODE_8_4:   return 3'(R_8_4);
      MODE_16_11: return 3'(R_16_11);
      default:    return 3'(R_32_26);
    endcase
  endfunction

  function automatic logic [5:0] ham_n(input ham_mode_e m);
    case (m)
      MODE_8_4:   return 6'(N_8_4);
      MODE_16_11: return 6'(N_16_11);
      default:    return 6'(N_32_26);
    endcase
  endfunction

endpackage

// File: rtl/ham_enc_if.sv
// Input/output streaming channels of the SECDED encoder.
// Injection controls exist only when ENC_ERR_INJECT_EN is defined.
interface ham_enc_if;
  import ham_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [MAX_INFO_WIDTH-1:0]     data_in;
  logic [1:0]                    mod;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] data_out;
  logic [1:0]                    out_mod;
  logic                          mod_err;
`ifdef ENC_ERR_INJECT_EN
  logic                          inj_en;
  logic                          inj_two;
  logic [POS_W-1:0]              inj_pos0;
  logic [POS_W-1:0]              inj_pos1;
`endif

  modport master (
    output in_valid, data_in, mod, out_ready,
`ifdef ENC_ERR_INJECT_EN
    output inj_en, inj_two, inj_pos0, inj_pos1,
`endif
    input  in_ready, out_valid, data_out, out_mod, mod_err
  );

  modport slave (
    input  in_valid, data_in, mod, out_ready,
`ifdef ENC_ERR_INJECT_EN
    input  inj_en, inj_two, inj_pos0, inj_pos1,
`endif
    output in_ready, out_valid, data_out, out_mod, mod_err
  );

endinterface

// File: rtl/ham_par_gen.sv
// Combinational SECDED parity: r bits (Hamming + overall), zero-padded to 6 bits.
// Expects info already masked to k bits for the mode.
module ham_par_gen
  import ham_pkg::*;
(
  input  logic [MAX_INFO_WIDTH-1:0] info,
  input  ham_mode_e                 mode,
  output logic [PAR_W-1:0]          par
);

  logic [HAM_W-1:0] h;
  logic             ovr;

  for (genvar j = 0; j < HAM_W; j++) begin : g_row
    localparam logic [MAX_INFO_WIDTH-1:0] ROW = ham_row_mask(j);
    assign h[j] = ^(info & ROW);
  end

  // With masked info, h bits above r-2 are zero, so one overall XOR serves all modes.
  assign ovr = (^info) ^ (^h);

  always_comb begin
    par = '0;
    case (mode)
      MODE_8_4:   par = {2'b00, ovr, h[2:0]};
      MODE_16_11: par = {1'b0, ovr, h[3:0]};
      MODE_32_26: par = {ovr, h};
      default:    par = '0;
    endcase
  end

endmodule

// File: rtl/ham_enc.sv
// Two-stage streaming extended-Hamming encoder for the (8,4), (16,11), (32,26) link modes.
// Define ENC_ERR_INJECT_EN to add per-beat bit-flip injection in stage 2.
module ham_enc
  import ham_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ham_enc_if.slave   bus
);

  logic                          adv1;
  logic                          adv2;
  logic                          accept;
  logic                          legal;
  logic                          s1_valid;
  logic                          s2_valid;
  ham_beat_t                     beat_d;
  ham_beat_t                     s1_q;
  logic [PAR_W-1:0]              par;
  logic [MAX_CODEWORD_WIDTH-1:0] data_d;
  logic [MAX_CODEWORD_WIDTH-1:0] data_q;
  logic [1:0]                    out_mod_q;
  logic                          mod_err_q;

  assign adv2        = !s2_valid || bus.out_ready;
  assign adv1        = !s1_valid || adv2;
  assign bus.in_ready = rst && adv1;
  assign accept      = bus.in_valid && bus.in_ready;
  assign legal       = (bus.mod != 2'b11);

  // Beat captured into stage 1: info masked to k bits.
  always_comb begin
    beat_d      = '0;
    beat_d.mode = ham_mode_e'(bus.mod);
    beat_d.info = bus.data_in & ham_info_mask(ham_mode_e'(bus.mod));
`ifdef ENC_ERR_INJECT_EN
    beat_d.inj_en   = bus.inj_en;
    beat_d.inj_two  = bus.inj_two;
    beat_d.inj_pos0 = bus.inj_pos0;
    beat_d.inj_pos1 = bus.inj_pos1;
`endif
  end

  // Illegal-mode beats are consumed here and never occupy stage 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      mod_err_q <= 1'b0;
    end else begin
      mod_err_q <= accept && !legal;
      if (adv1) begin
        s1_valid <= accept && legal;
        if (accept && legal) s1_q <= beat_d;
      end
    end
  end

  ham_par_gen u_par_gen (
    .info (s1_q.info),
    .mode (s1_q.mode),
    .par  (par)
  );

  // Systematic layout: info above parity; positions >= n are never flipped.
  always_comb begin
    data_d = (MAX_CODEWORD_WIDTH'(s1_q.info) << ham_r(s1_q.mode)) | MAX_CODEWORD_WIDTH'(par);
`ifdef ENC_ERR_INJECT_EN
    if (s1_q.inj_en && ({1'b0, s1_q.inj_pos0} < ham_n(s1_q.mode)))
      data_d[s1_q.inj_pos0] = ~data_d[s1_q.inj_pos0];
    if (s1_q.inj_en && s1_q.inj_two && (s1_q.inj_pos1 != s1_q.inj_pos0) &&
        ({1'b0, s1_q.inj_pos1} < ham_n(s1_q.mode)))
      data_d[s1_q.inj_pos1] = ~data_d[s1_q.inj_pos1];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid  <= 1'b0;
      data_q    <= '0;
      out_mod_q <= 2'b00;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_q    <= data_d;
        out_mod_q <= s1_q.mode;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.data_out  = data_q;
  assign bus.out_mod   = out_mod_q;
  assign bus.mod_err   = mod_err_q;

endmodule

// File: tb/tb_ham_enc.sv
// Bench for ham_enc: directed vectors plus random traffic against a column-XOR reference model.
// Injection checks are compiled in when ENC_ERR_INJECT_EN is defined.
module tb_ham_enc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ham_enc_if bus ();

  ham_enc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] cw;
    logic [1:0]  mode;
  } exp_t;

  exp_t        exp_q[$];
  logic        err_exp    = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic [1:0]  stall_mod  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Parity bits are the XOR of the columns of all set info bits; overall parity makes weight even.
  function automatic logic [31:0] model_cw(input logic [1:0] m, input logic [25:0] d);
    int unsigned k, r, col, par, ones;
    logic [31:0] cw;
    case (m)
      2'b00:   begin k = 4;  r = 4; end
      2'b01:   begin k = 11; r = 5; end
      default: begin k = 26; r = 6; end
    endcase
    par  = 0;
    col  = 3;
    ones = 0;
    cw   = '0;
    for (int unsigned i = 0; i < k; i++) begin
      while ((col & (col - 1)) == 0) col++;
      if (((d >> i) & 26'd1) != 0) begin
        par  = par ^ col;
        ones = ones + 1;
        cw   = cw | (32'd1 << (r + i));
      end
      col++;
    end
    ones = ones + $unsigned($countones(par));
    cw   = cw | 32'(par);
    if ((ones % 2) != 0) cw = cw | (32'd1 << (r - 1));
    return cw;
  endfunction

  function automatic logic [31:0] model_inj(input logic [31:0] cw, input logic [1:0] m,
                                            input logic en, input logic two,
                                            input logic [4:0] p0, input logic [4:0] p1);
    int unsigned n;
    logic [31:0] f;
    n = (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
    f = '0;
    if (en && (32'(p0) < n)) f = f | (32'd1 << p0);
    if (en && two && (32'(p1) < n)) f = f | (32'd1 << p1);
    return cw ^ f;
  endfunction

  // Scoreboard: handshakes seen before a rising edge take effect on that edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] c;
    if (!rst) begin
      exp_q.delete();
      err_exp    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("mod_err", 32'(bus.mod_err), 32'(err_exp));
      if (bus.mod_err) n_err++;
      if (stall_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", bus.data_out, stall_data);
        check("hold_mod", 32'(bus.out_mod), 32'(stall_mod));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.data_out;
      stall_mod  = bus.out_mod;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        check("out_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", bus.data_out, e.cw);
          check("out_mod", 32'(bus.out_mod), 32'(e.mode));
        end
      end
      err_exp = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        if (bus.mod == 2'b11) begin
          err_exp = 1'b1;
        end else begin
          c = model_cw(bus.mod, bus.data_in);
`ifdef ENC_ERR_INJECT_EN
          c = model_inj(c, bus.mod, bus.inj_en, bus.inj_two, bus.inj_pos0, bus.inj_pos1);
`endif
          e.cw   = c;
          e.mode = bus.mod;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipeline; codeword must show two cycles after it is presented.
  task automatic send_lat(input string tag, input logic [1:0] m, input logic [25:0] d,
                          input logic [31:0] exp);
    bus.in_valid  = 1'b1;
    bus.mod       = m;
    bus.data_in   = d;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.data_out, exp);
    check({tag, "_mode"}, 32'(bus.out_mod), 32'(m));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base_o, base_e;
    logic rdy;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.mod       = 2'b00;
    bus.out_ready = 1'b0;
`ifdef ENC_ERR_INJECT_EN
    bus.inj_en   = 1'b0;
    bus.inj_two  = 1'b0;
    bus.inj_pos0 = '0;
    bus.inj_pos1 = '0;
`endif
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    check("rst_out_mod", 32'(bus.out_mod), 32'd0);
    check("rst_mod_err", 32'(bus.mod_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Directed vectors, with garbage above k where possible.
    send_lat("m0_info1", 2'b00, 26'h2AB_CDE1, 32'h0000_001B);
    send_lat("m0_infoF", 2'b00, 26'h155_555F, 32'h0000_00FF);
    send_lat("m1_info1", 2'b01, 26'h3FF_F801, 32'h0000_0033);
    send_lat("m2_info1", 2'b10, 26'h000_0001, 32'h0000_0063);

    // Backpressure: five back-to-back beats, sink stalled for four cycles.
    acc    = 0;
    base_o = n_out;
    for (int c = 0; c < 40 && acc < 5; c++) begin
      bus.out_ready = (c >= 4);
      bus.in_valid  = 1'b1;
      bus.mod       = 2'(acc % 3);
      bus.data_in   = 26'($urandom);
      @(negedge clk);
      rdy = bus.in_ready;
      if (c < 2) check("bp_ready_high", 32'(rdy), 32'd1);
      if (c == 2 || c == 3) check("bp_ready_low", 32'(rdy), 32'd0);
      tick();
      if (rdy) acc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_accepts", 32'(acc), 32'd5);
    repeat (6) tick();
    check("bp_delivered", 32'(n_out - base_o), 32'd5);

    // Illegal mode between two legal beats.
    base_o = n_out;
    base_e = n_err;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.mod      = (i == 1) ? 2'b11 : 2'b00;
      bus.data_in  = 26'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("ill_err_pulses", 32'(n_err - base_e), 32'd1);
    check("ill_outputs", 32'(n_out - base_o), 32'd2);

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.mod      = 2'b01;
      bus.data_in  = 26'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", bus.data_out, 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_err", 32'(bus.mod_err), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    base_o = n_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_quiet", 32'(bus.out_valid), 32'd0);
    end
    check("post_rst_outs", 32'(n_out - base_o), 32'd0);

`ifdef ENC_ERR_INJECT_EN
    bus.inj_en   = 1'b1;
    bus.inj_pos0 = 5'd0;
    send_lat("inj_pos0", 2'b00, 26'h000_0001, 32'h0000_001A);
    bus.inj_two  = 1'b1;
    bus.inj_pos1 = 5'd7;
    send_lat("inj_two", 2'b00, 26'h000_0001, 32'h0000_009A);
    bus.inj_two  = 1'b0;
    bus.inj_pos0 = 5'd12;
    send_lat("inj_oob", 2'b00, 26'h000_0001, 32'h0000_001B);
    bus.inj_en   = 1'b0;
    bus.inj_pos0 = '0;
    bus.inj_pos1 = '0;
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom % 10) < 7;
      bus.mod       = (($urandom % 10) == 0) ? 2'b11 : 2'($urandom % 3);
      bus.data_in   = 26'($urandom);
      bus.out_ready = ($urandom % 10) < 7;
`ifdef ENC_ERR_INJECT_EN
      bus.inj_en   = ($urandom % 4) == 0;
      bus.inj_two  = ($urandom % 2) == 0;
      bus.inj_pos0 = 5'($urandom);
      bus.inj_pos1 = 5'($urandom);
`endif
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
